// File: rtl/weight_buffer_reader.sv
// weight_buffer_reader: walks a programmed address range of weight_buffer
// for one or more passes, issues read_req/read_addr, captures read_data
// on the following cycle and streams it to the PE array through a 2-entry
// skid FIFO.
//
// Handshake: a word moves on wt_data/wt_last in every cycle where
// wt_valid & wt_ready are both high. Once wt_valid is raised, it and the
// word under it hold until the handshake. wt_ready may change at any time.
module weight_buffer_reader #(
    parameter int RD_WIDTH      = 16,
    parameter int RD_ADDR_WIDTH = 7,
    parameter int PASS_WIDTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [RD_ADDR_WIDTH-1:0] base_addr,
    input  logic [RD_ADDR_WIDTH:0]   num_words,
    input  logic [PASS_WIDTH-1:0]    num_passes,
    output logic                     busy,
    output logic                     done,
    output logic                     read_req,
    output logic [RD_ADDR_WIDTH-1:0] read_addr,
    input  logic [RD_WIDTH-1:0]      read_data,
    output logic                     wt_valid,
    output logic [RD_WIDTH-1:0]      wt_data,
    output logic                     wt_last,
    input  logic                     wt_ready,
    output logic [1:0]               dbg_state
);

    localparam int CW = RD_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state;
    logic [RD_ADDR_WIDTH-1:0] base_q;
    logic [CW-1:0]            len_q;
    logic [PASS_WIDTH-1:0]    passes_q;
    logic [CW-1:0]            word_cnt;
    logic [PASS_WIDTH-1:0]    pass_cnt;

    // A read issued last cycle whose data is on read_data this cycle.
    logic                     inflight;
    logic                     inflight_last;

    logic [RD_WIDTH-1:0]      fifo_data [2];
    logic                     fifo_last [2];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic [1:0]               occ;

    logic                     pop;
    logic [2:0]               level;
    logic                     last_word;
    logic                     last_pass;
    logic                     drain_done;

    // Stream side and issue decision. level counts words that will sit in
    // the FIFO once the in-flight read lands, net of this cycle's pop; a
    // new read is allowed only while that leaves room for it.
    assign wt_valid   = (occ != 2'd0);
    assign pop        = wt_valid & wt_ready;
    assign wt_data    = fifo_data[rd_ptr];
    assign wt_last    = fifo_last[rd_ptr] & wt_valid;
    assign level      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign read_req   = (state == READ) && (level < 3'd2);
    assign last_word  = (word_cnt == len_q - CW'(1));
    assign last_pass  = (pass_cnt == passes_q - PASS_WIDTH'(1));
    assign drain_done = !inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop));
    assign busy       = (state == READ) || (state == DRAIN);
    assign done       = (state == DONE);
    assign dbg_state  = state;

    // Job sequencer: latches the job on start, walks addresses and passes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            passes_q  <= '0;
            word_cnt  <= '0;
            pass_cnt  <= '0;
            read_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        len_q     <= num_words;
                        passes_q  <= num_passes;
                        read_addr <= base_addr;
                        word_cnt  <= '0;
                        pass_cnt  <= '0;
                        if ((num_words == '0) || (num_passes == '0)) begin
                            state <= DONE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (read_req) begin
                        if (last_word) begin
                            read_addr <= base_q;
                            word_cnt  <= '0;
                            pass_cnt  <= pass_cnt + PASS_WIDTH'(1);
                            if (last_pass) begin
                                state <= DRAIN;
                            end
                        end else begin
                            read_addr <= read_addr + RD_ADDR_WIDTH'(1);
                            word_cnt  <= word_cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Capture path: read_data lands in the skid FIFO the cycle after its read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
            fifo_last[0]  <= 1'b0;
            fifo_last[1]  <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            occ           <= 2'd0;
        end else begin
            inflight      <= read_req;
            inflight_last <= read_req & last_word;
            if (inflight) begin
                fifo_data[wr_ptr] <= read_data;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_weight_buffer_reader.sv
// Directed bench for weight_buffer_reader with a weight_buffer memory model
// and an expected-word / expected-address scoreboard.
module tb_weight_buffer_reader;

    localparam int DW = 16;
    localparam int AW = 7;
    localparam int PW = 4;
    localparam int CW = AW + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] num_words;
    logic [PW-1:0] num_passes;
    logic          busy;
    logic          done;
    logic          read_req;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] read_data;
    logic          wt_valid;
    logic [DW-1:0] wt_data;
    logic          wt_last;
    logic          wt_ready;
    logic [1:0]    dbg_state;

    weight_buffer_reader #(
        .RD_WIDTH(DW), .RD_ADDR_WIDTH(AW), .PASS_WIDTH(PW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .base_addr(base_addr), .num_words(num_words), .num_passes(num_passes),
        .busy(busy), .done(done), .read_req(read_req), .read_addr(read_addr),
        .read_data(read_data), .wt_valid(wt_valid), .wt_data(wt_data),
        .wt_last(wt_last), .wt_ready(wt_ready), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a, 2'b01, a} ^ 16'h3C5A;
    endfunction

    // weight_buffer model: data valid the cycle after read_req, junk otherwise
    always @(posedge clk) begin
        read_data <= read_req ? mem_word(read_addr) : DW'($urandom);
    end

    // scoreboard state
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [DW:0]   exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic          exp_busy = 1'b0;
    logic          exp_done = 1'b0;
    int            outstanding = 0;
    logic          stalled_prev = 1'b0;
    logic [DW:0]   held = '0;
    int            cyc = 0;
    int            start_cyc = 0;
    int            first_req_cyc = -1;
    int            done_cyc = 0;
    int            job_reqs = 0;
    logic          done_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        addr_q.delete();
        exp_busy     = 1'b0;
        exp_done     = 1'b0;
        outstanding  = 0;
        stalled_prev = 1'b0;
    endtask

    // Per-cycle sampling at the falling edge; also advances the model.
    task automatic monitor();
        logic          pop;
        logic          fin;
        logic          cur_idle;
        logic [DW:0]   e;
        logic [AW-1:0] ea;
        logic [AW-1:0] a;
        cyc++;
        pop      = wt_valid && wt_ready;
        fin      = 1'b0;
        cur_idle = !exp_busy && !exp_done;
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        check("buffered_le_2", outstanding <= 2, 1);
        if (stalled_prev) begin
            check("stall_valid", wt_valid, 1);
            check("stall_hold", {wt_last, wt_data}, held);
        end
        if (read_req) begin
            job_reqs++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            check("req_expected", addr_q.size() != 0, 1);
            if (addr_q.size() != 0) begin
                ea = addr_q.pop_front();
                check("read_addr", read_addr, ea);
            end
        end
        if (pop) begin
            check("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wt_word", {wt_last, wt_data}, e);
                fin = exp_busy && (exp_q.size() == 0);
            end
        end
        outstanding  = outstanding + int'(read_req) - int'(pop);
        stalled_prev = wt_valid && !wt_ready;
        held         = {wt_last, wt_data};
        exp_done     = 1'b0;
        if (fin) begin
            exp_busy = 1'b0;
            exp_done = 1'b1;
        end else if (start && cur_idle) begin
            start_cyc     = cyc;
            first_req_cyc = -1;
            job_reqs      = 0;
            if (num_words == '0 || num_passes == '0) begin
                exp_done = 1'b1;
            end else begin
                exp_busy = 1'b1;
                for (int p = 0; p < int'(num_passes); p++) begin
                    for (int w = 0; w < int'(num_words); w++) begin
                        a = base_addr + AW'(w);
                        addr_q.push_back(a);
                        exp_q.push_back({(w == int'(num_words) - 1), mem_word(a)});
                    end
                end
            end
        end
    endtask

    // driver: one cycle with the given ready, returns just after the rising edge
    task automatic run_cycle(input logic rdy);
        wt_ready = rdy;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_ready(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 2 == 0);
            2:       return !(k >= 4 && k < 9);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_job(input logic [AW-1:0] b, input int len, input int passes,
                           input int mode, input logic poke);
        base_addr  = b;
        num_words  = CW'(len);
        num_passes = PW'(passes);
        done_seen  = 1'b0;
        start      = 1'b1;
        run_cycle(get_ready(mode, 0));
        start = 1'b0;
        for (int k = 1; k < 1000 && !done_seen; k++) begin
            if (poke && k == 3) begin
                start     = 1'b1;
                num_words = '0;
                base_addr = 7'd99;
            end
            run_cycle(get_ready(mode, k));
            start = 1'b0;
        end
        check("job_finished", done_seen, 1);
        check("queues_empty", exp_q.size() + addr_q.size(), 0);
        run_cycle(1'b1);
        run_cycle(1'b1);
    endtask

    task automatic check_outputs_cleared(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_read_req"}, read_req, 0);
        check({tag, "_read_addr"}, read_addr, 0);
        check({tag, "_wt_valid"}, wt_valid, 0);
        check({tag, "_wt_last"}, wt_last, 0);
        check({tag, "_wt_data"}, wt_data, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        num_words  = '0;
        num_passes = '0;
        wt_ready   = 1'b1;
        #1;
        check_outputs_cleared("reset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_cycle(1'b1);

        // 8 words, one pass, full throughput; job begins the cycle after start
        run_job(7'd0, 8, 1, 0, 1'b0);
        check("reqs_8", job_reqs, 8);
        check("done_latency_8", done_cyc - first_req_cyc, 10);

        // address wrap past the top of the buffer
        run_job(7'd126, 4, 1, 0, 1'b0);

        // three passes of three words
        run_job(7'd0, 3, 3, 0, 1'b0);
        check("reqs_3x3", job_reqs, 9);

        // ready toggling 1010...
        run_job(7'd10, 12, 2, 1, 1'b0);

        // ready low for 5 cycles mid-stream
        run_job(7'd20, 10, 1, 2, 1'b0);

        // start pulsed while busy is ignored
        run_job(7'd60, 6, 2, 0, 1'b1);

        // empty jobs: no reads, done the cycle after start
        run_job(7'd3, 0, 2, 0, 1'b0);
        check("reqs_len0", job_reqs, 0);
        check("done_latency_len0", done_cyc - start_cyc, 1);
        run_job(7'd3, 5, 0, 0, 1'b0);
        check("reqs_pass0", job_reqs, 0);
        check("done_latency_pass0", done_cyc - start_cyc, 1);

        // full-size pass with random backpressure
        run_job(7'd100, 128, 1, 3, 1'b0);
        check("reqs_128", job_reqs, 128);

        // reset in the middle of a job, then a fresh short job
        base_addr  = 7'd40;
        num_words  = CW'(100);
        num_passes = PW'(2);
        start      = 1'b1;
        run_cycle(1'b1);
        start = 1'b0;
        repeat (5) run_cycle(1'b0);
        reset_n = 1'b0;
        #1;
        check_outputs_cleared("midreset");
        clear_model();
        repeat (2) run_cycle(1'b1);
        reset_n = 1'b1;
        run_cycle(1'b1);
        run_job(7'd5, 2, 1, 0, 1'b0);
        check("reqs_after_reset", job_reqs, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
